// File: rtl/alu_pkg.sv
// alu_pkg: encodings and helpers shared by the ALU datapath stream blocks.
package alu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry output buffer (main + skid register) with an
// EMPTY/BUSY/FULL occupancy FSM; ready toward the source depends only on state.
module stream_skid_buf
  import alu_pkg::*;
#(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          push,
  output logic          can_accept,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  buf_state_e    state_r;
  buf_state_e    state_next_s;
  logic [DW-1:0] main_r;
  logic [DW-1:0] skid_r;
  logic          pop_s;

  assign pop_s = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode from push/pop
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (push) state_next_s = BUSY;
        else      state_next_s = EMPTY;
      end
      BUSY: begin
        if (push && !pop_s)      state_next_s = FULL;
        else if (pop_s && !push) state_next_s = EMPTY;
        else                     state_next_s = BUSY;
      end
      FULL: begin
        if (pop_s) state_next_s = BUSY;
        else       state_next_s = FULL;
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    out_valid  = (state_r != EMPTY);
    can_accept = (state_r != FULL);
    out_data   = main_r;
  end

  // Main/skid data registers; main only moves when it is empty or being popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push) main_r <= in_data;
        end
        BUSY: begin
          if (push && pop_s) main_r <= in_data;
          else if (push)     skid_r <= in_data;
        end
        FULL: begin
          if (pop_s) main_r <= skid_r;
        end
        default: begin
          main_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: registered N-way W-bit channel selector with valid/ready per channel
// and a 2-entry output skid buffer. Round-robin mode is built with STREAM_MUX_RR_EN.
module stream_mux
  import alu_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 4,
  parameter  int CNT_W = 16,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
`ifdef STREAM_MUX_RR_EN
  input  logic               mode,
`endif
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic                 can_accept_s;
  logic                 run_r;
  logic                 sel_bad_s;
  logic                 sel_grant_s;
  logic                 grant_vld_s;
  logic [SEL_W-1:0]     grant_s;
  logic                 accept_s;
  logic                 rr_mode_s;
  logic [SEL_W+W-1:0]   buf_in_s;
  logic [SEL_W+W-1:0]   buf_out_s;
  logic                 sel_err_r;
  logic [CNT_W-1:0]     xfer_cnt_r;

  assign sel_bad_s = (32'(sel) >= N);

  // Explicit-select grant
  always_comb begin
    sel_grant_s = 1'b0;
    if (!sel_bad_s) sel_grant_s = in_valid[sel];
    else            sel_grant_s = 1'b0;
  end

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] rr_g_s;
  logic             rr_vld_s;

  assign rr_mode_s = (mode == MODE_RR);

  // First valid channel at or after the pointer, wrapping mod N
  always_comb begin
    logic [SEL_W-1:0] idx_v;
    rr_vld_s = 1'b0;
    rr_g_s   = '0;
    idx_v    = '0;
    for (int k = 0; k < N; k++) begin
      idx_v = SEL_W'((32'(ptr_r) + 32'(k)) % N);
      if (!rr_vld_s && in_valid[idx_v]) begin
        rr_vld_s = 1'b1;
        rr_g_s   = idx_v;
      end else begin
      end
    end
  end

  // Grant source by mode
  always_comb begin
    if (rr_mode_s) begin
      grant_vld_s = rr_vld_s;
      grant_s     = rr_g_s;
    end else begin
      grant_vld_s = sel_grant_s;
      grant_s     = sel;
    end
  end

  // Round-robin pointer moves past the winner only on an accepted RR transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (accept_s && rr_mode_s) begin
      ptr_r <= SEL_W'((32'(grant_s) + 32'd1) % N);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  assign rr_mode_s = MODE_SEL;

  // Grant source: explicit select only
  always_comb begin
    grant_vld_s = sel_grant_s;
    grant_s     = sel;
  end
`endif

  // run_r holds ready low through reset and the first cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_r <= 1'b0;
    else        run_r <= 1'b1;
  end

  assign accept_s = grant_vld_s && can_accept_s && run_r;
  assign buf_in_s = {grant_s, in_data[32'(grant_s)*W +: W]};

  // One-hot ready on the granted channel
  always_comb begin
    in_ready = '0;
    if (accept_s) in_ready[grant_s] = 1'b1;
    else          in_ready = '0;
  end

  // Select-error pulse and accepted-transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r  <= 1'b0;
      xfer_cnt_r <= '0;
    end else begin
      sel_err_r <= sel_bad_s && !rr_mode_s;
      if (accept_s) xfer_cnt_r <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else          xfer_cnt_r <= xfer_cnt_r;
    end
  end

  stream_skid_buf #(.DW(SEL_W + W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (buf_in_s),
    .push       (accept_s),
    .can_accept (can_accept_s),
    .out_data   (buf_out_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  assign out_data = buf_out_s[W-1:0];
  assign out_chan = buf_out_s[W +: SEL_W];
  assign sel_err  = sel_err_r;
  assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed + random stimulus against a queue-based reference model.
module tb_stream_mux;

  localparam int N = 4, W = 4, CNT_W = 4, SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid, in_ready;
  logic [SEL_W-1:0] sel;
`ifdef STREAM_MUX_RR_EN
  logic             mode, mode3;
`endif
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_valid, out_ready, sel_err;
  logic [CNT_W-1:0] xfer_cnt;

  logic [3*W-1:0]   in_data3;
  logic [2:0]       in_valid3, in_ready3;
  logic [1:0]       sel3, out_chan3;
  logic [W-1:0]     out_data3;
  logic             out_valid3, out_ready3, sel_err3;
  logic [CNT_W-1:0] xfer_cnt3;

  logic [SEL_W+W-1:0] exp_q[$];
  int  m_cnt, m_ptr;
  bit  m_sel_err, m_run;
  int  checks, errors;

  always #5 clk = ~clk;

  stream_mux #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel),
`ifdef STREAM_MUX_RR_EN
    .mode(mode),
`endif
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
  );

  stream_mux #(.N(3), .W(W), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3),
`ifdef STREAM_MUX_RR_EN
    .mode(mode3),
`endif
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3), .xfer_cnt(xfer_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rr_on();
`ifdef STREAM_MUX_RR_EN
    return mode == 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_cnt = 0; m_ptr = 0; m_sel_err = 1'b0; m_run = 1'b0;
  endfunction

  // One clock: check DUT against the model at negedge, then advance the model
  task automatic step();
    int g; bit gv, acc, pop;
    logic [N-1:0] er;
    logic [SEL_W+W-1:0] ent;
    @(negedge clk);
    gv = 1'b0; g = 0;
    if (rr_on()) begin
      for (int k = 0; k < N; k++)
        if (!gv && in_valid[(m_ptr + k) % N]) begin gv = 1'b1; g = (m_ptr + k) % N; end
    end else if (int'(sel) < N && in_valid[sel]) begin
      gv = 1'b1; g = int'(sel);
    end
    acc = m_run && gv && (exp_q.size() < 2);
    er = '0;
    if (acc) er[g] = 1'b1;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0][W-1:0]);
      check("out_chan", out_chan, exp_q[0][W +: SEL_W]);
    end
    check("sel_err", sel_err, m_sel_err);
    check("xfer_cnt", xfer_cnt, m_cnt);
    ent = {g[SEL_W-1:0], in_data[g*W +: W]};
    pop = (exp_q.size() > 0) && out_ready;
    m_sel_err = !rr_on() && (int'(sel) >= N);
    @(posedge clk); #1;
    m_run = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(ent);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (rr_on()) m_ptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 4'hF; in_data = 16'($urandom); sel = 2'd0; out_ready = 1'b1;
    in_data3 = 12'h000; in_valid3 = 3'b000; sel3 = 2'd0; out_ready3 = 1'b1;
`ifdef STREAM_MUX_RR_EN
    mode = 1'b0; mode3 = 1'b0;
`endif
    model_clear();

    // Reset held 3 cycles with every channel valid
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 4'h0);
      check("rst_out_chan", out_chan, 2'd0);
      check("rst_sel_err", sel_err, 1'b0);
      check("rst_xfer_cnt", xfer_cnt, 4'h0);
      check("rst_in_ready", in_ready, 4'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step();

    // Explicit select of channel 2
    in_valid = 4'h0; repeat (3) step();
    sel = 2'd2; in_data = 16'($urandom); in_data[8 +: 4] = 4'hA; in_valid = 4'b0100;
    step();
    check("expl_valid", out_valid, 1'b1);
    check("expl_data", out_data, 4'hA);
    check("expl_chan", out_chan, 2'd2);
    in_valid = 4'h0; step();

    // Backpressure: two words fill the buffer, a third is refused
    out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    in_data[4 +: 4] = 4'h3; step();
    in_data[4 +: 4] = 4'h5; step();
    check("bp_full_ready", in_ready, 4'h0);
    check("bp_hold_data", out_data, 4'h3);
    in_data[4 +: 4] = 4'h7; step();
    in_valid = 4'h0; out_ready = 1'b1;
    repeat (3) step();

    // Random explicit-mode traffic
    repeat (60) begin
      in_valid = 4'($urandom); sel = 2'($urandom); in_data = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Counter wrap: 17 back-to-back transfers
    do_reset();
    sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    step();
    repeat (17) begin in_data = 16'($urandom); step(); end
    check("wrap_cnt", xfer_cnt, 4'd1);

    // Reset asserted while FULL
    in_valid = 4'b0001; out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0; #1;
    model_clear();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 4'h0);
    check("midrst_xfer_cnt", xfer_cnt, 4'h0);
    check("midrst_out_data", out_data, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
    repeat (3) step();

`ifdef STREAM_MUX_RR_EN
    // Round-robin: all valid, then channel 1 dropped, then random
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    repeat (6) step();
    in_valid = 4'b1101;
    repeat (5) step();
    repeat (40) begin
      in_valid = 4'($urandom); in_data = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    mode = 1'b0;
`endif

    // Out-of-range select on a 3-channel build
    in_valid3 = 3'b111; sel3 = 2'd3; in_data3 = 12'($urandom);
    @(negedge clk);
    check("bad_in_ready", in_ready3, 3'b000);
    check("bad_err_pre", sel_err3, 1'b0);
    @(posedge clk); #1;
    sel3 = 2'd0; in_valid3 = 3'b000;
    @(negedge clk);
    check("bad_err_pulse", sel_err3, 1'b1);
    check("bad_no_out", out_valid3, 1'b0);
    check("bad_no_cnt", xfer_cnt3, 4'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bad_err_clear", sel_err3, 1'b0);
    check("bad_no_out2", out_valid3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
